// File: rtl/pkg_processador.sv
// Shared definitions for the single-cycle processor: sequencer states,
// program counter width and the opcode constants decoded upstream.
package pkg_processador;

    localparam int unsigned PC_W     = 6;
    localparam int unsigned ESTADO_W = 3;
    localparam int unsigned OPC_W    = 4;

    // Sequencer states; encodings are visible on the debug LEDs
    typedef enum logic [ESTADO_W-1:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PASSO     = 3'd2,
        ESPERA_IO = 3'd3,
        HALT      = 3'd4
    } estado_t;

    // Opcodes seen by the instruction decoder
    localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OPC_JMP = 4'hA;
    localparam logic [OPC_W-1:0] OPC_CLR = 4'hC;
    localparam logic [OPC_W-1:0] OPC_RIO = 4'hD;

endpackage

// File: rtl/sincroniza_botao.sv
// Step pushbutton conditioner: two-flop synchroniser followed by a registered
// rising-edge detector. One single-cycle pulse per press, however long held.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   botao     - raw asynchronous button level
//   pulso     - one-cycle pulse, high after the third edge following the rise
module sincroniza_botao (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    output logic pulso
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 holds the previous synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulso <= 1'b0;
        end else begin
            s1    <= botao;
            s2    <= s1;
            s3    <= s2;
            pulso <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/controlador_execucao.sv
// Fetch/execute sequencer. Owns the program counter and a single execute
// strobe that gates every architectural write. Supports continuous run,
// single-step from a pushbutton and a stall for the external-input (RIO)
// instruction.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - leaves IDLE/HALT and begins execution
//   modo_passo      - 1 = single-step, 0 = continuous
//   botao_passo     - raw step pushbutton
//   Write_Pc        - load pc with endereco_Salto
//   endereco_Salto  - jump target
//   clear           - reset instruction, pc to 0
//   externo         - current instruction reads external input
//   io_valido       - external input data valid
//   pc              - instruction memory address
//   exec_en         - execute strobe (combinational)
//   io_req          - request to external input source (combinational)
//   estado          - current state encoding
//   contador_instr  - saturating executed-instruction count
module controlador_execucao
    import pkg_processador::*;
#(
    parameter int unsigned PROG_LAST = 63,
    parameter int unsigned WRAP      = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                modo_passo,
    input  logic                botao_passo,
    input  logic                Write_Pc,
    input  logic [PC_W-1:0]     endereco_Salto,
    input  logic                clear,
    input  logic                externo,
    input  logic                io_valido,
    output logic [PC_W-1:0]     pc,
    output logic                exec_en,
    output logic                io_req,
    output logic [ESTADO_W-1:0] estado,
    output logic [CNT_W-1:0]    contador_instr
);

    estado_t          estado_q;
    estado_t          estado_d;
    logic [PC_W-1:0]  pc_d;
    logic             pulso;
    logic             ultimo;

    sincroniza_botao u_sincroniza_botao (
        .clk   (clk),
        .rst   (rst),
        .botao (botao_passo),
        .pulso (pulso)
    );

    assign ultimo = (pc == PC_W'(PROG_LAST));
    assign estado = estado_q;

    // Next state, execute strobe, I/O request and next pc
    always_comb begin
        estado_d = estado_q;
        exec_en  = 1'b0;
        io_req   = 1'b0;
        pc_d     = pc;

        case (estado_q)
            IDLE: begin
                if (start) begin
                    estado_d = modo_passo ? PASSO : RUN;
                end
            end
            RUN: begin
                // An RIO instruction stalls before executing
                if (externo) begin
                    estado_d = ESPERA_IO;
                end else begin
                    exec_en = 1'b1;
                    if (modo_passo) begin
                        estado_d = PASSO;
                    end
                end
            end
            PASSO: begin
                if (pulso && externo) begin
                    estado_d = ESPERA_IO;
                end else begin
                    exec_en = pulso;
                    if (!modo_passo) begin
                        estado_d = RUN;
                    end
                end
            end
            ESPERA_IO: begin
                // Step pulses are ignored here; only io_valido completes
                io_req = 1'b1;
                if (io_valido) begin
                    exec_en  = 1'b1;
                    estado_d = modo_passo ? PASSO : RUN;
                end
            end
            HALT: begin
                if (start) begin
                    pc_d     = '0;
                    estado_d = modo_passo ? PASSO : RUN;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase

        // pc only moves on an executed instruction; clear beats jump
        if (exec_en) begin
            if (clear) begin
                pc_d = '0;
            end else if (Write_Pc) begin
                pc_d = endereco_Salto;
            end else if (ultimo) begin
                if (WRAP != 0) begin
                    pc_d = '0;
                end else begin
                    estado_d = HALT;
                end
            end else begin
                pc_d = pc + PC_W'(1);
            end
        end
    end

    // State, pc and saturating instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q       <= IDLE;
            pc             <= '0;
            contador_instr <= '0;
        end else begin
            estado_q <= estado_d;
            pc       <= pc_d;
            if (exec_en && (contador_instr != '1)) begin
                contador_instr <= contador_instr + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/controlador_execucao.md
Name: controlador_execucao

Overview:
- Fetch/execute sequencer for the single-cycle processor.
- Owns the 6-bit program counter that addresses instruction memory.
- Gates every architectural write (register bank, RAM, PC) through one execute strobe.
- Supports continuous run, single-step from a board pushbutton, and a stall for the external-input instruction (RIO).

Parameters:
PC_W, 6, program counter width; instruction memory depth is 2**PC_W
PROG_LAST, 63, last valid instruction address
WRAP, 1, 1 = PC wraps from PROG_LAST to 0; 0 = enter HALT at PROG_LAST
CNT_W, 16, width of executed-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  level; leaves IDLE/HALT and begins execution
modo_passo  in  1  1 = single-step mode, 0 = continuous
botao_passo  in  1  raw asynchronous step pushbutton, active-high
Write_Pc  in  1  decoder: load PC with endereco_Salto
endereco_Salto  in  PC_W  decoder: jump target
clear  in  1  decoder: reset instruction, PC to 0
externo  in  1  decoder: current instruction reads external input
io_valido  in  1  external input data valid
pc  out  PC_W  instruction memory address
exec_en  out  1  execute strobe; qualifies Enable_Write, Write_RAM and PC update
io_req  out  1  request to external input source
estado  out  3  current FSM state encoding, for debug LEDs
contador_instr  out  CNT_W  executed-instruction count, saturating

Behaviour:
- Reset (rst=1 at clk edge): pc=0, state=IDLE, contador_instr=0, step synchroniser flops=0. Combinational outputs follow: exec_en=0, io_req=0.
- States: IDLE=0, RUN=1, PASSO=2, ESPERA_IO=3, HALT=4.
- exec_en is combinational from state and inputs:
  - 1 in RUN when externo=0.
  - 1 in PASSO on a step pulse when externo=0.
  - 1 in ESPERA_IO when io_valido=1.
  - 0 in every other case.
- PC update, only on a clk edge where exec_en=1, in priority order:
  - clear: pc becomes 0.
  - Write_Pc: pc becomes endereco_Salto.
  - pc==PROG_LAST: pc becomes 0 if WRAP=1; if WRAP=0, pc holds and the next state is HALT.
  - Otherwise pc becomes pc+1, modulo 2**PC_W.
- contador_instr increments on every exec_en=1 edge and saturates at all-ones.
- IDLE:
  - start=1 moves to PASSO if modo_passo=1, else to RUN.
  - pc holds.
- RUN:
  - externo=1 moves to ESPERA_IO with exec_en=0 that cycle; the instruction is not executed yet.
  - modo_passo=1 moves to PASSO after completing the current instruction.
  - start is ignored.
- PASSO:
  - botao_passo passes through a 2-flop synchroniser, then a rising-edge detector; this gives a one-cycle pulse 3 edges after the input rises.
  - A pulse with externo=0 executes one instruction.
  - A pulse with externo=1 moves to ESPERA_IO.
  - modo_passo=0 moves to RUN.
  - A held button produces exactly one pulse.
- ESPERA_IO:
  - io_req=1 while in this state.
  - When io_valido=1, exec_en=1 that cycle (the datapath captures the external value) and the PC advances.
  - Next state is PASSO if modo_passo=1, else RUN.
  - io_req is 0 from the following cycle.
  - No timeout.
- HALT:
  - pc holds and exec_en=0.
  - start=1 sets pc to 0 and moves to RUN or PASSO according to modo_passo.
- Simultaneous events:
  - rst overrides everything, including mid-ESPERA_IO; io_req drops the same cycle the state becomes IDLE.
  - clear together with Write_Pc: clear wins.
  - externo together with Write_Pc: the I/O wait occurs first, then the jump applies on the io_valido cycle.
  - Step pulse while in ESPERA_IO: ignored.
- Latency: in RUN, one instruction per clk. In ESPERA_IO, the instruction completes on the first io_valido cycle.

Decomposition:
- Shared package pkg_processador holds the state typedef, encodings IDLE..HALT, PC_W and the opcode constants used by the decoder.
- One sub-module, sincroniza_botao: 2-flop synchroniser plus rising-edge detector producing a one-cycle pulse, with synchronous active-high rst.

Test Plan:
- Reset, start=1, modo_passo=0, no jumps/externo -> pc 0,1,2,... on consecutive clocks, exec_en=1, contador_instr=N after N cycles; at pc=63 next pc=0 (WRAP=1).
- Write_Pc=1, endereco_Salto=6'd40 at pc=5 -> next pc=40; same cycle with clear=1 -> next pc=0.
- externo=1 at pc=7, io_valido low for 4 cycles -> io_req=1, exec_en=0, pc=7 for 4 cycles; io_valido=1 -> exec_en=1 one cycle, pc=8, io_req=0 next.
- modo_passo=1, botao_passo held high 20 cycles -> exactly one exec_en pulse, 3 clocks after rise, pc advances by exactly 1.
- WRAP=0, run to pc=63 -> HALT (estado=4), pc stays 63, exec_en=0; start=1 -> pc=0, RUN.
- rst=1 during ESPERA_IO -> next edge pc=0, estado=IDLE, io_req=0, contador_instr=0.
